// File: rtl/adpcm_encoder_if.sv
// Sample-in / code-out stream bundle for the IMA ADPCM encoder.
interface adpcm_encoder_if #(
    parameter int unsigned WIDTH = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sop;
    logic                    in_eop;
    logic signed [WIDTH-1:0] in_pcm;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_sop;
    logic                    out_eop;
    logic [3:0]              out_code;
    logic signed [WIDTH-1:0] out_pred;
    logic [6:0]              out_index;
    logic                    drop;

    // Source/sink side: drives samples and out_ready, observes codes.
    modport master (
        output in_valid, in_sop, in_eop, in_pcm, out_ready,
        input  in_ready, out_valid, out_sop, out_eop, out_code, out_pred, out_index, drop
    );

    // Encoder side.
    modport slave (
        input  in_valid, in_sop, in_eop, in_pcm, out_ready,
        output in_ready, out_valid, out_sop, out_eop, out_code, out_pred, out_index, drop
    );
endinterface

// File: rtl/adpcm_encoder.sv
// IMA ADPCM encoder: one 4-bit code per 16-bit PCM sample, sop/eop framed streams.
module adpcm_encoder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DWIDTH = 8
) (
    input  logic           clk,
    input  logic           nrst,
    adpcm_encoder_if.slave bus
);
    localparam int unsigned SW = WIDTH + 1;
    localparam int unsigned PW = WIDTH + 2;
    localparam int unsigned IW = 7;
    localparam logic signed [PW-1:0]     PMAX = PW'(32767);
    localparam logic signed [PW-1:0]     PMIN = PW'(-32768);
    localparam logic signed [DWIDTH-1:0] IMAX = DWIDTH'(88);

    typedef enum logic {IDLE, RUN} state_e;

    state_e                   state_q, state_d;
    logic signed [WIDTH-1:0]  pred_q, pred_d;
    logic signed [DWIDTH-1:0] idx_q, idx_d;
    logic                     ovalid_q, ovalid_d;
    logic                     osop_q, osop_d;
    logic                     oeop_q, oeop_d;
    logic [3:0]               ocode_q, ocode_d;
    logic signed [WIDTH-1:0]  opred_q, opred_d;
    logic [IW-1:0]            oidx_q, oidx_d;
    logic                     drop_q, drop_d;

    logic                     in_ready_c;
    logic                     accept_c;
    logic signed [WIDTH-1:0]  base_pred;
    logic signed [DWIDTH-1:0] base_idx;
    logic signed [SW-1:0]     step;
    logic signed [SW-1:0]     diff;
    logic signed [SW-1:0]     mag;
    logic [3:0]               code;
    logic signed [PW-1:0]     dq;
    logic signed [PW-1:0]     psum;
    logic signed [WIDTH-1:0]  pred_new;
    logic signed [DWIDTH-1:0] adj;
    logic signed [DWIDTH-1:0] isum;
    logic signed [DWIDTH-1:0] idx_new;

    // Standard 89-entry IMA step-size table.
    function automatic logic [15:0] step_lut(input logic [IW-1:0] i);
        case (i)
            7'd0: step_lut = 16'd7;       7'd1: step_lut = 16'd8;       7'd2: step_lut = 16'd9;       7'd3: step_lut = 16'd10;
            7'd4: step_lut = 16'd11;      7'd5: step_lut = 16'd12;      7'd6: step_lut = 16'd13;      7'd7: step_lut = 16'd14;
            7'd8: step_lut = 16'd16;      7'd9: step_lut = 16'd17;      7'd10: step_lut = 16'd19;     7'd11: step_lut = 16'd21;
            7'd12: step_lut = 16'd23;     7'd13: step_lut = 16'd25;     7'd14: step_lut = 16'd28;     7'd15: step_lut = 16'd31;
            7'd16: step_lut = 16'd34;     7'd17: step_lut = 16'd37;     7'd18: step_lut = 16'd41;     7'd19: step_lut = 16'd45;
            7'd20: step_lut = 16'd50;     7'd21: step_lut = 16'd55;     7'd22: step_lut = 16'd60;     7'd23: step_lut = 16'd66;
            7'd24: step_lut = 16'd73;     7'd25: step_lut = 16'd80;     7'd26: step_lut = 16'd88;     7'd27: step_lut = 16'd97;
            7'd28: step_lut = 16'd107;    7'd29: step_lut = 16'd118;    7'd30: step_lut = 16'd130;    7'd31: step_lut = 16'd143;
            7'd32: step_lut = 16'd157;    7'd33: step_lut = 16'd173;    7'd34: step_lut = 16'd190;    7'd35: step_lut = 16'd209;
            7'd36: step_lut = 16'd230;    7'd37: step_lut = 16'd253;    7'd38: step_lut = 16'd279;    7'd39: step_lut = 16'd307;
            7'd40: step_lut = 16'd337;    7'd41: step_lut = 16'd371;    7'd42: step_lut = 16'd408;    7'd43: step_lut = 16'd449;
            7'd44: step_lut = 16'd494;    7'd45: step_lut = 16'd544;    7'd46: step_lut = 16'd598;    7'd47: step_lut = 16'd658;
            7'd48: step_lut = 16'd724;    7'd49: step_lut = 16'd796;    7'd50: step_lut = 16'd876;    7'd51: step_lut = 16'd963;
            7'd52: step_lut = 16'd1060;   7'd53: step_lut = 16'd1166;   7'd54: step_lut = 16'd1282;   7'd55: step_lut = 16'd1411;
            7'd56: step_lut = 16'd1552;   7'd57: step_lut = 16'd1707;   7'd58: step_lut = 16'd1878;   7'd59: step_lut = 16'd2066;
            7'd60: step_lut = 16'd2272;   7'd61: step_lut = 16'd2499;   7'd62: step_lut = 16'd2749;   7'd63: step_lut = 16'd3024;
            7'd64: step_lut = 16'd3327;   7'd65: step_lut = 16'd3660;   7'd66: step_lut = 16'd4026;   7'd67: step_lut = 16'd4428;
            7'd68: step_lut = 16'd4871;   7'd69: step_lut = 16'd5358;   7'd70: step_lut = 16'd5894;   7'd71: step_lut = 16'd6484;
            7'd72: step_lut = 16'd7132;   7'd73: step_lut = 16'd7845;   7'd74: step_lut = 16'd8630;   7'd75: step_lut = 16'd9493;
            7'd76: step_lut = 16'd10442;  7'd77: step_lut = 16'd11487;  7'd78: step_lut = 16'd12635;  7'd79: step_lut = 16'd13899;
            7'd80: step_lut = 16'd15289;  7'd81: step_lut = 16'd16818;  7'd82: step_lut = 16'd18500;  7'd83: step_lut = 16'd20350;
            7'd84: step_lut = 16'd22385;  7'd85: step_lut = 16'd24623;  7'd86: step_lut = 16'd27086;  7'd87: step_lut = 16'd29794;
            default: step_lut = 16'd32767;
        endcase
    endfunction

    // Input side stalls only while a code is parked waiting for the sink.
    assign in_ready_c = !ovalid_q || bus.out_ready;
    assign accept_c   = bus.in_valid && in_ready_c;

    // Quantise the sample against the effective predictor, then reconstruct like the decoder.
    always_comb begin
        base_pred = bus.in_sop ? '0 : pred_q;
        base_idx  = bus.in_sop ? '0 : idx_q;
        step      = $signed({1'b0, step_lut(IW'(base_idx))});
        diff      = SW'(bus.in_pcm) - SW'(base_pred);
        code      = 4'd0;
        mag       = diff;
        if (diff < 0) begin
            code[3] = 1'b1;
            mag     = -diff;
        end
        if (mag >= step) begin
            code[2] = 1'b1;
            mag     = mag - step;
        end
        if (mag >= (step >>> 1)) begin
            code[1] = 1'b1;
            mag     = mag - (step >>> 1);
        end
        if (mag >= (step >>> 2)) begin
            code[0] = 1'b1;
        end
        dq = PW'(step >>> 3)
           + (code[2] ? PW'(step)        : '0)
           + (code[1] ? PW'(step >>> 1)  : '0)
           + (code[0] ? PW'(step >>> 2)  : '0);
        psum = code[3] ? PW'(base_pred) - dq : PW'(base_pred) + dq;
        if (psum > PMAX) begin
            pred_new = WIDTH'(PMAX);
        end else if (psum < PMIN) begin
            pred_new = WIDTH'(PMIN);
        end else begin
            pred_new = WIDTH'(psum);
        end
        case (code[2:0])
            3'd4:    adj = DWIDTH'(2);
            3'd5:    adj = DWIDTH'(4);
            3'd6:    adj = DWIDTH'(6);
            3'd7:    adj = DWIDTH'(8);
            default: adj = DWIDTH'(-1);
        endcase
        isum = base_idx + adj;
        if (isum < 0) begin
            idx_new = '0;
        end else if (isum > IMAX) begin
            idx_new = IMAX;
        end else begin
            idx_new = isum;
        end
    end

    // Frame FSM next state plus predictor and output-register updates.
    always_comb begin
        state_d  = state_q;
        pred_d   = pred_q;
        idx_d    = idx_q;
        ovalid_d = ovalid_q && !bus.out_ready;
        osop_d   = osop_q;
        oeop_d   = oeop_q;
        ocode_d  = ocode_q;
        opred_d  = opred_q;
        oidx_d   = oidx_q;
        drop_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c && bus.in_sop && !bus.in_eop) begin
                    state_d = RUN;
                end
                if (accept_c && !bus.in_sop) begin
                    drop_d = 1'b1;
                end
            end
            RUN: begin
                if (accept_c && bus.in_eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept_c && (state_q == RUN || bus.in_sop)) begin
            pred_d   = pred_new;
            idx_d    = idx_new;
            ovalid_d = 1'b1;
            osop_d   = bus.in_sop;
            oeop_d   = bus.in_eop;
            ocode_d  = code;
            opred_d  = pred_new;
            oidx_d   = IW'(idx_new);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            pred_q   <= '0;
            idx_q    <= '0;
            ovalid_q <= 1'b0;
            osop_q   <= 1'b0;
            oeop_q   <= 1'b0;
            ocode_q  <= '0;
            opred_q  <= '0;
            oidx_q   <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pred_q   <= pred_d;
            idx_q    <= idx_d;
            ovalid_q <= ovalid_d;
            osop_q   <= osop_d;
            oeop_q   <= oeop_d;
            ocode_q  <= ocode_d;
            opred_q  <= opred_d;
            oidx_q   <= oidx_d;
            drop_q   <= drop_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = ovalid_q;
    assign bus.out_sop   = osop_q;
    assign bus.out_eop   = oeop_q;
    assign bus.out_code  = ocode_q;
    assign bus.out_pred  = opred_q;
    assign bus.out_index = oidx_q;
    assign bus.drop      = drop_q;
endmodule

// File: doc/adpcm_encoder.md
# adpcm_encoder

IMA ADPCM encoder: compresses a framed stream of signed 16-bit PCM samples into 4-bit codes, one code per sample. It is the transmit-side counterpart of the ADPCM decoder in the MP3-Player audio path. Its predictor and step-index state machine follows exactly the same arithmetic as the decoder, so a decoder fed the emitted codes from the same frame start rebuilds `out_pred` bit-exactly. The input and output are valid/ready streams framed with sop/eop.

## Interface
- `WIDTH`, 16, PCM sample width; only 16 is supported.
- `DWIDTH`, 8, width of the signed step-index register.
- `clk`  in  1  clock; all state changes on the rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  PCM sample valid.
- `in_ready`  out  1  encoder can accept a sample.
- `in_sop`  in  1  first sample of a frame; qualified by `in_valid`.
- `in_eop`  in  1  last sample of a frame; qualified by `in_valid`.
- `in_pcm`  in  16  signed PCM sample.
- `out_valid`  out  1  code valid.
- `out_ready`  in  1  downstream accepts the code.
- `out_sop` / `out_eop`  out  1  frame markers, aligned with the code for the same sample.
- `out_code`  out  4  ADPCM code: bit 3 is the sign, bits 2:0 are the magnitude.
- `out_pred`  out  16  reconstructed predictor after this code.
- `out_index`  out  7  step index after this code (0..88).
- `drop`  out  1  one-cycle pulse when a sample arriving outside a frame is discarded.

## Operation
- FSM has two states, IDLE and RUN. Reset puts it in IDLE.
- Accept condition: `in_valid && in_ready`. `in_ready` = `!out_valid || out_ready` in both states.
- IDLE:
  - An accepted sample with `in_sop` is encoded and moves the FSM to RUN. If `in_eop` is also set, the FSM stays in IDLE.
  - An accepted sample without `in_sop` is discarded, raises `drop` for one cycle, and changes no other state.
- RUN:
  - Every accepted sample is encoded.
  - An accepted sample with `in_eop` returns the FSM to IDLE.
  - An accepted `in_sop` restarts the frame. The predictor is re-initialised for that sample and the FSM stays in RUN.
- Effective state for encoding: pred=0 and index=0 if the sample carries sop; otherwise the registered pred and index. `step = stepsizetable[index]`, the standard 89-entry IMA table from 7 to 32767.
- Quantisation, all in 17-bit signed arithmetic:
  - `d = pcm - pred`. If d<0, set c[3]=1 and d = -d.
  - If d >= step: set c[2], d -= step.
  - If d >= step>>1: set c[1], d -= step>>1.
  - If d >= step>>2: set c[0].
- Reconstruction:
  - `dq = (step>>3) + (c2?step:0) + (c1?step>>1:0) + (c0?step>>2:0)`.
  - `pred_new = c3 ? pred-dq : pred+dq`, saturated to [-32768, 32767].
  - `index_new = index + {-1,-1,-1,-1,2,4,6,8}[c[2:0]]`, clamped to [0, 88].
- On accept, load registered pred/index with pred_new/index_new. Load the output register with `code`, `pred_new`, `index_new` and the sop/eop flags.
- The output register holds its contents while `out_valid && !out_ready`. `out_valid` clears when the code is taken with no new accept.

## Timing
- Reset values: `out_valid`=0, `out_code`=0, `out_pred`=0, `out_index`=0, `out_sop`=0, `out_eop`=0, `drop`=0, `in_ready`=1. Registered pred=0, index=0, FSM=IDLE.
- Latency: a sample accepted at edge N produces `out_valid` high after edge N.
- Throughput: one sample per cycle while `out_ready` stays high.
- Backpressure: `in_ready` falls combinationally when `out_valid && !out_ready`. Output data is stable until taken.
- `drop` is asserted in the cycle after the discarding accept.
- Deasserting `nrst` mid-frame immediately clears all state and outputs. A pending code is lost, and the next frame must begin with sop.

## Test plan
- Reset, then sop sample 100 followed by eop sample 0 -> codes 0x7 (pred 11, index 8), then 0xA (pred 1, index 7). `out_sop` is set on the first code, `out_eop` on the second, and the FSM ends in IDLE.
- Saturation: sop sample 32767 followed by 40 samples of 32767, then -32768 samples -> `out_pred` never exceeds 32767 or goes below -32768, `out_index` never exceeds 88, and no wrap occurs. A long run of 0x0/0x8 codes drives the index back to 0 and holds it there.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 -> exactly one code is held stable, `in_ready`=0 throughout, and no sample is lost or duplicated.
- Out-of-frame: a sample without sop while in IDLE -> `drop` pulses once and `out_valid` stays 0. A sample with sop and eop on the same beat -> one code carrying both `out_sop` and `out_eop`.
- Mid-frame sop restart: after 10 samples, a sop sample 100 -> code 0x7 and pred 11, identical to a fresh frame.
- Random 1000-sample frame with random `out_ready`: feeding the codes through a reference decoder model reproduces `out_pred` bit-exactly.
